reg_release_unit: RTL and testbench

Commit-side return path for physical register tags. Accepts up to three retiring instructions per cycle and filters out those with no tag to free. Queues the old physical tags in an 8-entry FIFO and drains up to three per cycle into the rename free list's three write ports. It is the producer feeding the free list that rename allocates from, and is throttled by the free list's reported room.

---
 rtl/reg_release_if.sv | 23 ++
 rtl/reg_release_unit.sv | 56 +++++
 tb/tb_reg_release_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/reg_release_if.sv
// reg_release_if: commit-side release inputs and free-list write port bundle.
interface reg_release_if #(parameter int PHYS_REGS = 64, parameter int QUEUE_DEPTH = 8);
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int QA_W = $clog2(QUEUE_DEPTH);
  logic [2:0] commit_valid;
  logic [2:0] commit_has_dest;
  logic [2:0][TAG_W-1:0] commit_old_tag;
  logic release_ready;
  logic [TAG_W:0] fl_room;
  logic fl_recover;
  logic [2:0] fl_write_en;
  logic [2:0][TAG_W-1:0] fl_write_tag;
  logic [QA_W:0] pending_count;
  logic overflow_err;
  modport master (
    output commit_valid, commit_has_dest, commit_old_tag, fl_room, fl_recover,
    input release_ready, fl_write_en, fl_write_tag, pending_count, overflow_err
  );
  modport slave (
    input commit_valid, commit_has_dest, commit_old_tag, fl_room, fl_recover,
    output release_ready, fl_write_en, fl_write_tag, pending_count, overflow_err
  );
endinterface

// File: rtl/reg_release_unit.sv
// reg_release_unit: queues freed physical tags from commit and drains up to three per cycle into the free list.
module reg_release_unit #(
  parameter int PHYS_REGS = 64,
  parameter int QUEUE_DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  reg_release_if.slave bus
);
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int QA_W = $clog2(QUEUE_DEPTH);
  logic [TAG_W-1:0] r_q [QUEUE_DEPTH];
  logic [QA_W:0] r_rd, r_wr, w_occ;
  logic r_ovf;
  logic [2:0] w_elig;
  logic [1:0] w_off [3];
  logic [1:0] w_enq, w_lim, w_deq;
  logic w_acc;
  always_comb begin
    for (int k = 0; k < 3; k++)
      w_elig[k] = bus.commit_valid[k] & bus.commit_has_dest[k] & (|bus.commit_old_tag[k]);
    w_off[0] = 2'd0;
    w_off[1] = {1'b0, w_elig[0]};
    w_off[2] = w_off[1] + {1'b0, w_elig[1]};
    w_enq = w_off[2] + {1'b0, w_elig[2]};
    w_occ = r_wr - r_rd;
    w_acc = w_occ <= (QA_W+1)'(QUEUE_DEPTH - 3);
    w_lim = w_occ < (QA_W+1)'(3) ? w_occ[1:0] : 2'd3;
    w_deq = bus.fl_recover ? 2'd0 : bus.fl_room < (TAG_W+1)'(w_lim) ? bus.fl_room[1:0] : w_lim;
    for (int j = 0; j < 3; j++) begin
      bus.fl_write_en[j] = 2'(j) < w_deq;
      bus.fl_write_tag[j] = bus.fl_write_en[j] ? r_q[r_rd[QA_W-1:0] + QA_W'(j)] : '0;
    end
  end
  assign bus.release_ready = w_acc;
  assign bus.pending_count = w_occ;
  assign bus.overflow_err = r_ovf;
  // an overfull cycle drops the whole group so program order is never split
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd <= '0;
      r_wr <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_rd <= r_rd + (QA_W+1)'(w_deq);
      r_wr <= r_wr + (w_acc ? (QA_W+1)'(w_enq) : '0);
      r_ovf <= r_ovf | ((|w_enq) & ~w_acc);
    end
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (w_elig[k] && w_acc) r_q[r_wr[QA_W-1:0] + QA_W'(w_off[k])] <= bus.commit_old_tag[k];
  always_ff @(posedge clk)
    if (rst_n)
      assert ((TAG_W+1)'(w_deq) <= bus.fl_room && (QA_W+1)'(w_deq) <= w_occ)
      else $warning("reg_release_unit: drain exceeds free-list room or occupancy");
endmodule

// File: tb/tb_reg_release_unit.sv
// tb_reg_release_unit: directed checks of release filtering, FIFO drain, overflow, wrap and async reset.
module tb_reg_release_unit;
  localparam int TAG_W = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n = 0;
  int fails = 0;
  logic [TAG_W-1:0] q[$];
  reg_release_if #(.PHYS_REGS(64), .QUEUE_DEPTH(8)) bus ();
  reg_release_unit #(.PHYS_REGS(64), .QUEUE_DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] v, input logic [2:0] d,
                       input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2);
    bus.commit_valid = v;
    bus.commit_has_dest = d;
    bus.commit_old_tag[0] = t0;
    bus.commit_old_tag[1] = t1;
    bus.commit_old_tag[2] = t2;
    #1;
  endtask
  initial begin
    bus.commit_valid = '0;
    bus.commit_has_dest = '0;
    bus.commit_old_tag = '0;
    bus.fl_room = 7'd32;
    bus.fl_recover = 1'b0;
    #12;
    chk("rst_pending", bus.pending_count, 0);
    chk("rst_ready", bus.release_ready, 1);
    chk("rst_en", bus.fl_write_en, 0);
    chk("rst_tags", bus.fl_write_tag, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    rst_n = 1'b1;
    // filter: slot 1 has no destination
    drive(3'b111, 3'b101, 6'd5, 6'd9, 6'd7);
    chk("t1_empty_en", bus.fl_write_en, 0);
    tick;
    drive(3'b000, 3'b000, 0, 0, 0);
    chk("t1_pending", bus.pending_count, 2);
    chk("t1_en", bus.fl_write_en, 3'b011);
    chk("t1_tag0", bus.fl_write_tag[0], 5);
    chk("t1_tag1", bus.fl_write_tag[1], 7);
    chk("t1_tag2", bus.fl_write_tag[2], 0);
    tick;
    chk("t1_drained", bus.pending_count, 0);
    chk("t1_en_off", bus.fl_write_en, 0);
    // tag 0 is never released
    drive(3'b111, 3'b111, 6'd0, 6'd12, 6'd13);
    tick;
    drive(3'b000, 3'b000, 0, 0, 0);
    chk("t2_en", bus.fl_write_en, 3'b011);
    chk("t2_tag0", bus.fl_write_tag[0], 12);
    chk("t2_tag1", bus.fl_write_tag[1], 13);
    tick;
    chk("t2_pending", bus.pending_count, 0);
    // no room: fill then overflow
    bus.fl_room = 7'd0;
    drive(3'b111, 3'b111, 6'd20, 6'd21, 6'd22);
    tick;
    chk("t3_pending3", bus.pending_count, 3);
    chk("t3_ready3", bus.release_ready, 1);
    chk("t3_en_room0", bus.fl_write_en, 0);
    drive(3'b111, 3'b111, 6'd23, 6'd24, 6'd25);
    tick;
    chk("t3_pending6", bus.pending_count, 6);
    chk("t3_ready6", bus.release_ready, 0);
    drive(3'b111, 3'b111, 6'd26, 6'd27, 6'd28);
    tick;
    chk("t3_hold6", bus.pending_count, 6);
    chk("t3_ovf", bus.overflow_err, 1);
    drive(3'b000, 3'b000, 0, 0, 0);
    // throttled drain and recovery stall
    bus.fl_room = 7'd2;
    #1;
    chk("t4_en_a", bus.fl_write_en, 3'b011);
    chk("t4_tag_a0", bus.fl_write_tag[0], 20);
    chk("t4_tag_a1", bus.fl_write_tag[1], 21);
    tick;
    chk("t4_pending4", bus.pending_count, 4);
    chk("t4_tag_b0", bus.fl_write_tag[0], 22);
    chk("t4_tag_b1", bus.fl_write_tag[1], 23);
    tick;
    bus.fl_recover = 1'b1;
    #1;
    chk("t4_recover_en", bus.fl_write_en, 0);
    tick;
    bus.fl_recover = 1'b0;
    #1;
    chk("t4_hold2", bus.pending_count, 2);
    chk("t4_tag_c0", bus.fl_write_tag[0], 24);
    chk("t4_tag_c1", bus.fl_write_tag[1], 25);
    tick;
    chk("t4_empty", bus.pending_count, 0);
    chk("t4_ovf_sticky", bus.overflow_err, 1);
    // asynchronous reset with five queued
    bus.fl_room = 7'd0;
    drive(3'b111, 3'b111, 6'd40, 6'd41, 6'd42);
    tick;
    drive(3'b011, 3'b011, 6'd43, 6'd44, 6'd0);
    tick;
    drive(3'b000, 3'b000, 0, 0, 0);
    chk("t6_pending5", bus.pending_count, 5);
    bus.fl_room = 7'd32;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", bus.pending_count, 0);
    chk("t6_rst_en", bus.fl_write_en, 0);
    chk("t6_rst_ovf", bus.overflow_err, 0);
    chk("t6_rst_ready", bus.release_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    drive(3'b001, 3'b001, 6'd33, 6'd0, 6'd0);
    tick;
    drive(3'b000, 3'b000, 0, 0, 0);
    chk("t6_post_en", bus.fl_write_en, 3'b001);
    chk("t6_post_tag", bus.fl_write_tag[0], 33);
    tick;
    chk("t6_post_empty", bus.pending_count, 0);
    // random commits with ample room; drained order must match eligible order
    bus.fl_room = 7'd64;
    for (int c = 0; c < 44; c++) begin
      logic [2:0] v, d;
      logic [TAG_W-1:0] t [3];
      v = (c < 40) ? 3'($urandom) : 3'b000;
      d = 3'($urandom);
      for (int k = 0; k < 3; k++) t[k] = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      drive(v, d, t[0], t[1], t[2]);
      chk("rnd_ready", bus.release_ready, 1);
      chk("rnd_en0", bus.fl_write_en[0], q.size() != 0);
      for (int j = 0; j < 3; j++)
        if (bus.fl_write_en[j]) chk("rnd_tag", bus.fl_write_tag[j], q.size() != 0 ? q.pop_front() : 6'd0);
        else chk("rnd_idle_tag", bus.fl_write_tag[j], 0);
      for (int k = 0; k < 3; k++)
        if (v[k] && d[k] && t[k] != 0) q.push_back(t[k]);
      tick;
    end
    chk("rnd_all_drained", q.size(), 0);
    chk("rnd_pending", bus.pending_count, 0);
    chk("rnd_ovf", bus.overflow_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
